// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Iterative multiply/divide unit for the EX stage. Executes MULT, MULTU, DIV
// and DIVU one bit per cycle (DATA_W iterations). It owns the HI/LO registers,
// services MTHI/MTLO, and asks the pipeline to stall any HI/LO access while an
// operation is in flight.
//
// Ports:
//   i_clk      clock, all state changes on the rising edge
//   i_reset    synchronous active-high reset
//   i_start    launch an operation (honoured only in IDLE)
//   i_op       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   i_rs       multiplicand / dividend
//   i_rt       multiplier / divisor
//   i_mthi     write i_wdata to HI (honoured only in IDLE)
//   i_mtlo     write i_wdata to LO (honoured only in IDLE)
//   i_wdata    data for MTHI/MTLO
//   i_hilo_rd  an MFHI/MFLO is in EX this cycle
//   o_hi/o_lo  HI and LO registers
//   o_busy     state is not IDLE
//   o_done     one-cycle pulse in DONE, HI/LO already updated
//   o_stall    o_busy & (i_hilo_rd | i_start | i_mthi | i_mtlo)
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_rs,
  input  logic [DATA_W-1:0] i_rt,
  input  logic              i_mthi,
  input  logic              i_mtlo,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_hilo_rd,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_stall
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                is_div;
  logic                neg_main;   // product / quotient sign
  logic                neg_rem;    // remainder sign
  logic [DATA_W-1:0]   opb;        // multiplicand or divisor magnitude
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide: lower half holds dividend bits shifting out / quotient shifting in.
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   rem;

  // Launch decode
  logic              op_signed, rs_neg, rt_neg, div_zero, last;
  logic [DATA_W-1:0] rs_mag, rt_mag;

  assign op_signed = ~i_op[0];
  assign rs_neg    = op_signed & i_rs[DATA_W-1];
  assign rt_neg    = op_signed & i_rt[DATA_W-1];
  assign rs_mag    = rs_neg ? -i_rs : i_rs;
  assign rt_mag    = rt_neg ? -i_rt : i_rt;
  assign div_zero  = i_op[1] && (i_rt == '0);
  assign last      = (cnt == CNT_LAST);

  // Shift-add step: add multiplicand when the current multiplier LSB is set,
  // then shift the whole accumulator right by one.
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_acc;

  assign mul_sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opb} : '0);
  assign mul_acc = {mul_sum, acc[DATA_W-1:1]};

  // Restoring division step on a DATA_W+1 partial remainder. The stored
  // remainder is always below the divisor, so the shifted value fits and the
  // MSB of the difference is a clean borrow flag.
  logic [DATA_W:0]   div_shift, div_diff;
  logic              div_ok;
  logic [DATA_W-1:0] div_rem, div_quo;

  assign div_shift = {rem, acc[DATA_W-1]};
  assign div_diff  = div_shift - {1'b0, opb};
  assign div_ok    = ~div_diff[DATA_W];
  assign div_rem   = div_ok ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
  assign div_quo   = {acc[DATA_W-2:0], div_ok};

  // Sign-corrected final results, used only on the last iteration.
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix;

  assign prod_fix = neg_main ? -mul_acc : mul_acc;
  assign quo_fix  = neg_main ? -div_quo : div_quo;
  assign rem_fix  = neg_rem  ? -div_rem : div_rem;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch forms.
    state_nxt = state;
    unique case (state)
      IDLE: if (i_start) state_nxt = div_zero ? DONE : RUN;
      RUN:  if (last)    state_nxt = DONE;
      DONE:              state_nxt = IDLE;
      default:           state_nxt = IDLE;
    endcase
  end

  // Datapath and HI/LO
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_hi     <= '0;
      o_lo     <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      opb      <= '0;
      acc      <= '0;
      rem      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_start) begin
            if (div_zero) begin
              o_hi <= i_rs;
              o_lo <= '1;
            end
            cnt      <= '0;
            is_div   <= i_op[1];
            neg_main <= rs_neg ^ rt_neg;
            neg_rem  <= rs_neg;
            // Multiply: rt is the multiplier (consumed from acc), rs the
            // multiplicand. Divide: rs is the dividend, rt the divisor.
            opb      <= i_op[1] ? rt_mag : rs_mag;
            acc      <= {{DATA_W{1'b0}}, (i_op[1] ? rs_mag : rt_mag)};
            rem      <= '0;
          end else begin
            if (i_mthi) o_hi <= i_wdata;
            if (i_mtlo) o_lo <= i_wdata;
          end
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (is_div) begin
            acc[DATA_W-1:0] <= div_quo;
            rem             <= div_rem;
          end else begin
            acc <= mul_acc;
          end
          if (last) begin
            if (is_div) begin
              o_hi <= rem_fix;
              o_lo <= quo_fix;
            end else begin
              o_hi <= prod_fix[2*DATA_W-1:DATA_W];
              o_lo <= prod_fix[DATA_W-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy  = (state != IDLE);
  assign o_done  = (state == DONE);
  assign o_stall = o_busy & (i_hilo_rd | i_start | i_mthi | i_mtlo);

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
// Directed bench for mult_div_unit. The stimulus process pushes the expected
// HI/LO of every completing operation into a scoreboard queue; an independent
// monitor pops and compares on each o_done pulse. Latency, busy, stall and
// reset behaviour are checked inline by the stimulus process.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

  localparam int DW = 32;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_start;
  logic [1:0]    i_op;
  logic [DW-1:0] i_rs, i_rt, i_wdata;
  logic          i_mthi, i_mtlo, i_hilo_rd;
  logic [DW-1:0] o_hi, o_lo;
  logic          o_busy, o_done, o_stall;

  mult_div_unit #(.DATA_W(DW), .CNT_W(6)) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_start   (i_start),
    .i_op      (i_op),
    .i_rs      (i_rs),
    .i_rt      (i_rt),
    .i_mthi    (i_mthi),
    .i_mtlo    (i_mtlo),
    .i_wdata   (i_wdata),
    .i_hilo_rd (i_hilo_rd),
    .o_hi      (o_hi),
    .o_lo      (o_lo),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_stall   (o_stall)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string         name;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Monitor: every o_done cycle must match the oldest outstanding expectation.
  always @(negedge i_clk) begin
    if (o_done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_hi"}, 64'(o_hi), 64'(e.hi));
        check({e.name, "_lo"}, 64'(o_lo), 64'(e.lo));
      end
    end
  end

  // Launch one operation, wait for it to finish and return to IDLE, then check
  // the cycles from start presentation to o_done and the busy duration.
  task automatic run_op(input string name, input logic [1:0] op,
                        input logic [DW-1:0] rs, input logic [DW-1:0] rt,
                        input logic [DW-1:0] exp_hi, input logic [DW-1:0] exp_lo,
                        input int exp_cycles);
    int cycles, lat, busy_cnt;
    bit finished;
    exp_t e;
    e.name = name; e.hi = exp_hi; e.lo = exp_lo;
    sb.push_back(e);
    i_op = op; i_rs = rs; i_rt = rt; i_start = 1'b1;
    step();
    i_start = 1'b0;
    cycles = 1; lat = 0; busy_cnt = 0; finished = 0;
    for (int k = 0; k < 100; k++) begin
      if (o_busy) busy_cnt++;
      if (o_done && lat == 0) lat = cycles;
      if (!o_busy) begin
        finished = 1;
        break;
      end
      step();
      cycles++;
    end
    check({name, "_finished"}, 64'(finished), 64'd1);
    check({name, "_done_cycle"}, 64'(lat), 64'(exp_cycles));
    check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_cycles));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_done;
    i_reset = 1'b1; i_start = 1'b0; i_op = '0; i_rs = '0; i_rt = '0;
    i_mthi = 1'b0; i_mtlo = 1'b0; i_wdata = '0; i_hilo_rd = 1'b0;
    step();
    step();
    i_reset = 1'b0;
    step();
    check("reset_hilo", {o_hi, o_lo}, 64'd0);
    check("reset_busy_done", {62'd0, o_busy, o_done}, 64'd0);

    // Main function
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33);
    run_op("mult_neg",  OP_MULT,  -32'sd7, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 33);
    run_op("div_neg",   OP_DIV,   -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_op("div_negrt", OP_DIV,   32'd7, -32'sd2, 32'h0000_0001, 32'hFFFF_FFFD, 33);
    run_op("divu_zero", OP_DIVU,  32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1);

    // Requests during RUN: stalled, ignored, HI/LO untouched until DONE.
    begin
      exp_t e;
      e.name = "divu_busy"; e.hi = 32'd6; e.lo = 32'd142;
      sb.push_back(e);
      i_op = OP_DIVU; i_rs = 32'd1000; i_rt = 32'd7; i_start = 1'b1; i_hilo_rd = 1'b1;
      step();
      i_op = OP_MULTU; i_rs = 32'd9; i_rt = 32'd9;
      i_mthi = 1'b1; i_wdata = 32'hDEAD_BEEF;
      seen_done = 0;
      for (int k = 0; k < 100; k++) begin
        if (o_done) begin
          seen_done = 1;
          break;
        end
        check("run_stall", 64'(o_stall), 64'd1);
        check("run_hilo_held", {o_hi, o_lo}, {32'd100, 32'hFFFF_FFFF});
        step();
      end
      check("busy_op_done", 64'(seen_done), 64'd1);
      i_start = 1'b0; i_mthi = 1'b0; i_hilo_rd = 1'b0;
      step();
      check("second_start_idle0", 64'(o_busy), 64'd0);
      step();
      check("second_start_idle1", 64'(o_busy), 64'd0);
      check("mthi_ignored", 64'(o_hi), 64'd6);
    end

    // Reset mid-RUN abandons the operation.
    i_op = OP_DIV; i_rs = 32'h8000_0000; i_rt = 32'hFFFF_FFFF; i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (10) step();
    check("pre_reset_busy", 64'(o_busy), 64'd1);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    check("midrun_reset_busy_done", {62'd0, o_busy, o_done}, 64'd0);
    check("midrun_reset_hilo", {o_hi, o_lo}, 64'd0);
    repeat (40) step();
    check("post_reset_quiet", 64'(o_busy), 64'd0);
    i_mtlo = 1'b1; i_wdata = 32'h0000_1234;
    step();
    i_mtlo = 1'b0;
    check("mtlo_after_reset", {o_hi, o_lo}, {32'd0, 32'h0000_1234});
    i_mthi = 1'b1; i_mtlo = 1'b1; i_wdata = 32'hCAFE_0001;
    step();
    i_mthi = 1'b0; i_mtlo = 1'b0;
    check("mthi_mtlo_both", {o_hi, o_lo}, {32'hCAFE_0001, 32'hCAFE_0001});

    // Signed overflow boundary, then back-to-back launch.
    run_op("div_ovf",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);
    run_op("mult_m1",  OP_MULT,  32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hEDCB_A988, 33);
    run_op("multu_b2b", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 33);

    step();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit with its sequencing FSM, living beside the ALU in the EX stage. It executes MULT, MULTU, DIV and DIVU over DATA_W+1 cycles. It owns the HI/LO registers and also services MTHI and MTLO. It drives a stall request so the pipeline holds any HI/LO access until the result is ready.

## Interface
Parameters:
- DATA_W, 32, operand, HI and LO width. Iteration count equals DATA_W.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > DATA_W.

Ports:
- i_clk  in  1  single clock. All state changes on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  request to launch an operation. Honoured only in IDLE.
- i_op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- i_rs  in  DATA_W  multiplicand or dividend.
- i_rt  in  DATA_W  multiplier or divisor.
- i_mthi  in  1  write i_wdata to HI. Honoured only in IDLE.
- i_mtlo  in  1  write i_wdata to LO. Honoured only in IDLE.
- i_wdata  in  DATA_W  data for MTHI and MTLO.
- i_hilo_rd  in  1  an MFHI or MFLO is in EX this cycle.
- o_hi  out  DATA_W  HI register, registered.
- o_lo  out  DATA_W  LO register, registered.
- o_busy  out  1  high when state is not IDLE.
- o_done  out  1  one-cycle pulse in DONE. HI and LO are already updated in that cycle.
- o_stall  out  1  combinational: o_busy & (i_hilo_rd | i_start | i_mthi | i_mtlo).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE to RUN on i_start:
  - Latch the operand magnitudes. Signed ops take the absolute value; unsigned ops pass operands through.
  - Latch the result sign flags: product/quotient sign is rs_sign XOR rt_sign; remainder sign is rs_sign.
  - Clear the counter.
- IDLE to DONE directly on i_start with a DIV or DIVU and i_rt == 0:
  - Divide-by-zero bypass: HI <= i_rs, LO <= all ones. No RUN cycles.
- RUN, multiply: shift-add, one multiplier bit per cycle, LSB first. Uses a 2*DATA_W accumulator.
- RUN, divide: restoring division, one quotient bit per cycle, MSB first. Uses a DATA_W+1 partial remainder.
- RUN, counter increments each cycle. When the counter reaches DATA_W-1, that iteration completes and:
  - sign-corrected results are written (multiply: HI = upper half, LO = lower half; divide: LO = quotient, HI = remainder),
  - the FSM moves to DONE.
- DONE to IDLE unconditionally after one cycle.
- Sign correction is two's-complement negation of the full 2*DATA_W product, or of the quotient and remainder separately.
- Signed overflow case: DIV of most-negative by -1 gives LO = 0x80000000, HI = 0. This follows naturally from the magnitude arithmetic.
- MTHI and MTLO in IDLE write at the next edge. If both are asserted, both registers take i_wdata.
- i_start together with i_mthi or i_mtlo in IDLE: i_start wins; the move is discarded. The decoder never issues both at once.
- Requests arriving in RUN or DONE are ignored. The pipeline holds them via o_stall and re-presents them.
- Reset at any point, including mid-RUN: state IDLE, counter 0, HI = 0, LO = 0, o_busy = 0, o_done = 0. The in-flight operation is abandoned.

## Timing
- Start sampled at edge E0 gives RUN for DATA_W cycles (E1..E32 iterations for DATA_W = 32).
- HI and LO are written at E32, the edge the FSM enters DONE.
- o_done is high from E32 to E33. A new i_start is accepted at E33 (IDLE again) at the earliest.
- Divide-by-zero: start at E0, HI and LO written at E0, o_done high from E0 to E1.
- o_busy rises the cycle after the start edge. A MFHI arriving the very next cycle sees o_stall = 1.
- o_hi and o_lo are stable between writes. Intermediate accumulator values are never visible on them.

## Test plan
- MULTU: 0xFFFFFFFF × 0xFFFFFFFF. Expect HI = 0xFFFFFFFE, LO = 0x00000001, o_done exactly 33 cycles after start, o_busy high for 33 cycles.
- MULT: −7 × 6. Expect HI = 0xFFFFFFFF, LO = 0xFFFFFFD6. DIV: −7 / 2. Expect LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 100 / 0. Expect o_done the cycle after start, HI = 100, LO = 0xFFFFFFFF, o_busy high for 1 cycle only.
- During RUN, assert i_hilo_rd, i_mthi and a second i_start. Expect o_stall = 1 each cycle, HI/LO unchanged until DONE, the second start ignored.
- Start DIV 0x80000000 / 0xFFFFFFFF, assert i_reset at RUN cycle 10. Expect IDLE next cycle, HI = LO = 0, no o_done pulse. Then MTLO 0x1234 writes LO = 0x1234 in 1 cycle.
- Back-to-back: start MULTU 3 × 5 at the first idle cycle after DONE. Expect LO = 15, HI = 0, with no lost or duplicated o_done.
